// File: rtl/uart_pkg.sv
// Shared definitions for the UART clocking blocks: default divisor
// settings, oversample ratio and the divisor-update state encoding.
package uart_pkg;

  // Default geometry of the fractional baud generator.
  localparam int UART_INT_W    = 16;
  localparam int UART_FRAC_W   = 8;
  localparam int UART_OSR      = 16;

  // Divisor active straight out of reset.
  localparam int UART_DEF_INT  = 326;
  localparam int UART_DEF_FRAC = 0;

  // Divisor update handshake: STABLE when the active divisor is current,
  // PENDING while a newly loaded shadow divisor waits for a safe swap point.
  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } upd_state_e;

endpackage

// File: rtl/frac_tick_div.sv
// Fractional tick divider: a down-counter paced by a phase accumulator.
// Each oversample period lasts eff_int clocks plus the carry out of the
// accumulator, so the long-run period averages int + frac/2^FRAC_W.
module frac_tick_div
  import uart_pkg::*;
#(
  parameter int INT_W   = UART_INT_W,
  parameter int FRAC_W  = UART_FRAC_W,
  parameter int DEF_INT = UART_DEF_INT
) (
  input  logic              clock,
  input  logic              reset,        // asynchronous, active low
  input  logic              enable,
  input  logic              sync_clear,
  input  logic [INT_W-1:0]  act_int,      // currently active integer divisor
  input  logic [FRAC_W-1:0] act_frac,     // currently active fractional divisor
  input  logic              swap_pending, // shadow divisor becomes active at next reload
  input  logic [INT_W-1:0]  shadow_int,   // integer divisor that the swap installs
  output logic              tick_os
);

  // Divisors 0 and 1 would give a zero-length period; they run as 2.
  localparam int             DEF_EFF = (DEF_INT < 2) ? 2 : DEF_INT;
  localparam logic [INT_W:0] CNT_RST = (INT_W+1)'(DEF_EFF - 1);
  localparam logic [INT_W:0] CNT_ONE = (INT_W+1)'(1);

  // Counter is one bit wider than the divisor so eff_int+carry always fits.
  function automatic logic [INT_W:0] eff_div(input logic [INT_W-1:0] d);
    if (d[INT_W-1:1] == '0) begin
      return (INT_W+1)'(2);
    end
    return {1'b0, d};
  endfunction

  logic [INT_W:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;

  logic [INT_W:0]  act_eff;
  logic [INT_W:0]  shd_eff;
  logic [FRAC_W:0] acc_sum;
  logic [INT_W:0]  carry_ext;

  // Clamped divisors and the accumulator step taken at each tick.
  always_comb begin
    act_eff   = eff_div(act_int);
    shd_eff   = eff_div(shadow_int);
    acc_sum   = {1'b0, acc_q} + {1'b0, act_frac};
    carry_ext = {{INT_W{1'b0}}, acc_sum[FRAC_W]};
  end

  // A tick fires when the count is exhausted, unless frozen or being cleared.
  assign tick_os = enable & ~sync_clear & (cnt_q == '0);

  // Next count / accumulator: clear restarts phase, tick reloads, else count down.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (sync_clear) begin
      // A pending shadow is installed by the clear, so restart on its length.
      cnt_d = (swap_pending ? shd_eff : act_eff) - CNT_ONE;
      acc_d = '0;
    end else if (tick_os) begin
      if (swap_pending) begin
        // New divisor starts with a clean accumulator and no carry.
        cnt_d = shd_eff - CNT_ONE;
        acc_d = '0;
      end else begin
        cnt_d = act_eff + carry_ext - CNT_ONE;
        acc_d = acc_sum[FRAC_W-1:0];
      end
    end else if (enable) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Counter and accumulator registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= CNT_RST;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator. Produces an oversample tick, a bit-rate
// tick and a square baud clock. New divisors are staged in a shadow and
// swapped in only at a period boundary (or on sync_clear), so a divisor
// change never produces a short or runt period.
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int INT_W    = UART_INT_W,
  parameter int FRAC_W   = UART_FRAC_W,
  parameter int OSR      = UART_OSR,
  parameter int DEF_INT  = UART_DEF_INT,
  parameter int DEF_FRAC = UART_DEF_FRAC,
  localparam int PH_W    = $clog2(OSR)
) (
  input  logic              clock,
  input  logic              reset,      // asynchronous, active low
  input  logic              enable,
  input  logic              sync_clear,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              div_busy,
  output logic              tick_os,
  output logic              tick_baud,
  output logic              baud_out,
  output logic [PH_W-1:0]   os_phase
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OSR / 2 - 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  upd_state_e        state_q, state_d;
  logic [INT_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [INT_W-1:0]  shd_int_q, shd_int_d;
  logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              baud_q, baud_d;

  logic              tick_os_w;
  logic              pending;
  logic              swap_now;
  logic              phase_last;
  logic              phase_mid;

  assign pending    = (state_q == PENDING);
  assign swap_now   = pending & (sync_clear | tick_os_w);
  assign phase_last = (phase_q == PH_LAST);
  assign phase_mid  = (phase_q == PH_MID);

  frac_tick_div #(
    .INT_W   (INT_W),
    .FRAC_W  (FRAC_W),
    .DEF_INT (DEF_INT)
  ) u_div (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .sync_clear   (sync_clear),
    .act_int      (act_int_q),
    .act_frac     (act_frac_q),
    .swap_pending (pending),
    .shadow_int   (shd_int_q),
    .tick_os      (tick_os_w)
  );

  // Divisor update: capture into shadow on load, install at the next swap point.
  always_comb begin
    state_d    = state_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    shd_int_d  = shd_int_q;
    shd_frac_d = shd_frac_q;
    // The swap always installs the shadow as it stood before this cycle's load.
    if (swap_now) begin
      act_int_d  = shd_int_q;
      act_frac_d = shd_frac_q;
      state_d    = STABLE;
    end
    // A load (even on the swap cycle) leaves a fresh value waiting.
    if (div_load) begin
      shd_int_d  = div_int;
      shd_frac_d = div_frac;
      state_d    = PENDING;
    end
  end

  // Oversample index and square baud clock, advanced on each tick.
  always_comb begin
    phase_d = phase_q;
    baud_d  = baud_q;
    if (sync_clear) begin
      phase_d = '0;
      baud_d  = 1'b0;
    end else if (tick_os_w) begin
      phase_d = phase_last ? '0 : phase_q + PH_ONE;
      if (phase_last || phase_mid) begin
        baud_d = ~baud_q;
      end
    end
  end

  // Update-FSM and divisor registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= STABLE;
      act_int_q  <= INT_W'(DEF_INT);
      act_frac_q <= FRAC_W'(DEF_FRAC);
      shd_int_q  <= INT_W'(DEF_INT);
      shd_frac_q <= FRAC_W'(DEF_FRAC);
    end else begin
      state_q    <= state_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
    end
  end

  // Phase and baud-clock registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      baud_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      baud_q  <= baud_d;
    end
  end

  assign div_busy  = pending;
  assign tick_os   = tick_os_w;
  assign tick_baud = tick_os_w & phase_last;
  assign baud_out  = baud_q;
  assign os_phase  = phase_q;

endmodule
